// File: rtl/pc_seq.sv
// Program-counter sequencer: fetch handshake, next-PC resolution with a return-address stack.
// Optional vectored interrupt support is compiled in with `define PCSEQ_IRQ_EN.
module pc_seq #(
   parameter int          RAS_DEPTH = 8,
   parameter logic [15:0] RESET_VEC = 16'h0000,
   parameter logic [15:0] IRQ_VEC   = 16'h0004
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [15:0]                  pc_q,
   output logic                         pc_en,
   output logic                         pc_inc,
   output logic [15:0]                  pc_d,
   output logic                         imem_req,
   input  logic                         imem_ack,
   output logic                         ir_valid,
   input  logic                         ex_done,
   input  logic [2:0]                   ex_op,
   input  logic [15:0]                  ex_target,
   input  logic                         irq,
   output logic                         irq_ack,
   output logic                         halted,
   output logic [$clog2(RAS_DEPTH):0]   ras_cnt,
   output logic                         ras_err
);

   localparam int AW = $clog2(RAS_DEPTH);
   localparam int CW = AW + 1;

   localparam logic [2:0] OP_JUMP = 3'd1;
   localparam logic [2:0] OP_CALL = 3'd2;
   localparam logic [2:0] OP_RET  = 3'd3;
   localparam logic [2:0] OP_HALT = 3'd4;
   localparam logic [2:0] OP_RETI = 3'd5;

   typedef enum logic [2:0] {S_LOAD, S_FETCH, S_EXEC, S_CHK, S_HALT} state_t;

   state_t        state, nstate;
   logic [15:0]   ras [RAS_DEPTH];
   logic          push, pop, err_set;
   logic [15:0]   push_val;
   logic          ras_full, ras_empty;
   logic [AW-1:0] top_idx;
   logic [15:0]   ras_top;

`ifdef PCSEQ_IRQ_EN
   logic ie, ie_clr, ie_set;
`else
   logic unused_irq;
   localparam logic [15:0] UNUSED_IRQ_VEC = IRQ_VEC;
   assign unused_irq = irq;
`endif

   assign ras_full  = (ras_cnt == CW'(RAS_DEPTH));
   assign ras_empty = (ras_cnt == '0);
   assign top_idx   = AW'(ras_cnt - CW'(1));
   assign ras_top   = ras[top_idx];

   // Outputs are decoded from state and inputs; everything is forced quiet while rst is high.
   always_comb begin
      nstate   = state;
      pc_en    = 1'b0;
      pc_inc   = 1'b0;
      pc_d     = '0;
      imem_req = 1'b0;
      ir_valid = 1'b0;
      irq_ack  = 1'b0;
      push     = 1'b0;
      pop      = 1'b0;
      err_set  = 1'b0;
      push_val = pc_q + 16'd1;
`ifdef PCSEQ_IRQ_EN
      ie_clr   = 1'b0;
      ie_set   = 1'b0;
`endif
      if (!rst) begin
         case (state)
            S_LOAD: begin
               pc_en  = 1'b1;
               pc_d   = RESET_VEC;
               nstate = S_FETCH;
            end
            S_FETCH: begin
               imem_req = 1'b1;
               if (imem_ack) begin
                  ir_valid = 1'b1;
                  nstate   = S_EXEC;
               end
            end
            S_EXEC: begin
               if (ex_done) begin
                  nstate = S_CHK;
                  case (ex_op)
                     OP_JUMP: begin
                        pc_en = 1'b1;
                        pc_d  = ex_target;
                     end
                     OP_CALL: begin
                        pc_en = 1'b1;
                        pc_d  = ex_target;
                        push  = 1'b1;
                     end
                     OP_RET, OP_RETI: begin
                        if (!ras_empty) begin
                           pc_en = 1'b1;
                           pc_d  = ras_top;
                           pop   = 1'b1;
                        end else begin
                           pc_inc  = 1'b1;
                           err_set = 1'b1;
                        end
`ifdef PCSEQ_IRQ_EN
                        if (ex_op == OP_RETI) ie_set = 1'b1;
`endif
                     end
                     OP_HALT: begin
                        pc_inc = 1'b1;
                        nstate = S_HALT;
                     end
                     default: pc_inc = 1'b1;
                  endcase
               end
            end
            S_CHK: begin
               nstate = S_FETCH;
`ifdef PCSEQ_IRQ_EN
               // pc_q already holds the resume address when we get here
               if (irq && ie) begin
                  push     = 1'b1;
                  push_val = pc_q;
                  pc_en    = 1'b1;
                  pc_d     = IRQ_VEC;
                  irq_ack  = 1'b1;
                  ie_clr   = 1'b1;
               end
`endif
            end
            S_HALT: begin
`ifdef PCSEQ_IRQ_EN
               if (irq && ie) nstate = S_CHK;
`endif
            end
            default: nstate = S_LOAD;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_LOAD;
         ras_cnt <= '0;
         ras_err <= 1'b0;
         halted  <= 1'b0;
`ifdef PCSEQ_IRQ_EN
         ie      <= 1'b1;
`endif
      end else begin
         state  <= nstate;
         halted <= (nstate == S_HALT);
         if (push) begin
            if (ras_full) ras_err <= 1'b1;
            else          ras_cnt <= ras_cnt + CW'(1);
         end
         if (pop)     ras_cnt <= ras_cnt - CW'(1);
         if (err_set) ras_err <= 1'b1;
`ifdef PCSEQ_IRQ_EN
         if (ie_clr)      ie <= 1'b0;
         else if (ie_set) ie <= 1'b1;
`endif
      end
   end

   // Stack storage is plain data; only the occupancy count is reset.
   always_ff @(posedge clk) begin
      if (push && !ras_full) ras[ras_cnt[AW-1:0]] <= push_val;
   end

endmodule

// File: doc/pc_seq.md
Name: pc_seq

Overview:
- Program-counter sequencer for the 16-bit core. It drives the PC register's load (en), increment (inc) and data (d) inputs, and reads back the current PC value.
- Runs the fetch handshake with instruction memory and waits for the execute stage to finish.
- Resolves next-PC: sequential, jump, call or return, using an internal return-address stack (RAS).
- Handles halt, and optionally a single vectored interrupt.

Parameters:
- RAS_DEPTH, 8, number of return-address stack entries (power of two, 2..32).
- RESET_VEC, 16'h0000, PC loaded after reset.
- IRQ_VEC, 16'h0004, PC loaded on interrupt entry (used only with PCSEQ_IRQ_EN).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- pc_q  in  16  current PC value, from the PC register
- pc_en  out  1  load PC from pc_d
- pc_inc  out  1  increment PC
- pc_d  out  16  PC load value
- imem_req  out  1  fetch request; the address is pc_q
- imem_ack  in  1  fetch complete
- ir_valid  out  1  one-cycle pulse: fetched instruction is valid
- ex_done  in  1  execute stage finished; qualifies ex_op and ex_target
- ex_op  in  3  0 NEXT, 1 JUMP, 2 CALL, 3 RET, 4 HALT, 5 RETI, 6/7 treated as NEXT
- ex_target  in  16  jump/call destination
- irq  in  1  level interrupt request
- irq_ack  out  1  one-cycle pulse on interrupt entry
- halted  out  1  high in HALT state
- ras_cnt  out  $clog2(RAS_DEPTH)+1  number of RAS entries occupied
- ras_err  out  1  sticky RAS overflow/underflow flag

Behaviour:
- State register: LOAD, FETCH, EXEC, CHK, HALT. Registered: state, RAS contents, ras_cnt, ras_err, ie (interrupt enable).
- pc_en, pc_inc, pc_d, imem_req, ir_valid and irq_ack are combinational from state and inputs.
- pc_en and pc_inc are never high in the same cycle.
- pc_d = 0 whenever pc_en = 0.
- Reset (any state, any cycle):
  - next state LOAD; ras_cnt=0; ras_err=0; ie=1.
  - All combinational outputs are 0 during the rst cycle.
  - A fetch or execute in progress is abandoned; a late imem_ack or ex_done is ignored.
- LOAD: pc_en=1, pc_d=RESET_VEC for one cycle, then → FETCH.
- FETCH: imem_req=1 while waiting. On the imem_ack cycle, ir_valid=1 and → EXEC. No timeout.
- EXEC: wait for ex_done. In the ex_done cycle, act on ex_op, then go to the listed state:
  - NEXT: pc_inc=1 → CHK.
  - JUMP: pc_en=1, pc_d=ex_target → CHK.
  - CALL:
    - Push pc_q+1 (mod 2^16) onto the RAS; ras_cnt+1. pc_en=1, pc_d=ex_target → CHK.
    - If ras_cnt==RAS_DEPTH: push dropped, ras_err set, jump still taken.
  - RET:
    - If ras_cnt>0: pc_en=1, pc_d=top entry, ras_cnt-1.
    - If ras_cnt==0: ras_err set, pc_inc=1 instead.
    - → CHK.
  - RETI: as RET, and also sets ie=1.
  - HALT: pc_inc=1 → HALT.
- CHK: one cycle; interrupt check only (see Optional Feature). Otherwise → FETCH.
- HALT: halted=1, no outputs active; leaves only on reset or interrupt.
- Sequential latency:
  - ex_done edge → PC updated at that edge.
  - CHK the next cycle.
  - imem_req asserted 2 cycles after ex_done.
- RAS is LIFO. Wrap-around of pc_q+1 at 16'hFFFF gives 16'h0000.
- ras_err clears only on reset.

Optional Feature:
- Macro: PCSEQ_IRQ_EN.
- Defined:
  - In CHK with irq && ie: push pc_q (it already holds the resume address); pc_en=1, pc_d=IRQ_VEC; irq_ack=1; ie cleared → FETCH.
  - On RAS full: push dropped, ras_err set, vector still taken.
  - In HALT with irq && ie: → CHK, which takes the interrupt, so the resume address is the instruction after HALT.
- Undefined:
  - irq ignored; irq_ack tied 0; ie logic removed; RETI behaves exactly as RET.
  - HALT is exited only by reset.

Test Plan:
- Reset, imem_ack after 3 cycles of imem_req, ex_done with NEXT → pc_en pulse with pc_d=0000; ir_valid 1 cycle; PC 0000→0001; imem_req reasserted 2 cycles after ex_done.
- PC=0010, CALL target 0100, then RET → RAS holds 0011, ras_cnt 1→0; PC 0010→0100→0011.
- RAS_DEPTH+1 nested CALLs, then RAS_DEPTH+1 RETs → ras_err set on the 9th CALL. The last RET increments PC instead of loading it. ras_cnt never exceeds 8 nor goes below 0.
- PC=FFFF, CALL target 0200 → pushed value 0000.
- HALT at 0020 → halted=1, no imem_req for 50 cycles.
  - With PCSEQ_IRQ_EN, irq=1: irq_ack, PC=0004, RAS top=0021; RETI returns PC to 0021 with ie=1.
- rst asserted mid-FETCH with imem_ack coincident → LOAD next cycle, ras_cnt=0, ras_err=0, no ir_valid.
